pll_lock_sequencer: RTL

- Controller for a Cyclone V `altera_pll` instance, clocked from the PLL's own 50 MHz reference clock.
- Generates the PLL reset pulse at start-up and qualifies the PLL `locked` output with a debounce interval.
- Holds the downstream system reset until lock is stable, and re-sequences the PLL on lock loss or lock timeout.
- Escalates to a sticky fail state after repeated failed lock attempts.

---
 rtl/pll_lock_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL start-up / lock qualification sequencer for a Cyclone V altera_pll.
// Pulses the PLL reset, debounces locked, gates the system reset and retries on timeout.
module pll_lock_sequencer #(
    parameter int RST_CYCLES     = 10,
    parameter int LOCK_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int RETRY_MAX      = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       req,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retries,
    output logic [7:0] loss_count
);

    localparam int MAX_RL  = (RST_CYCLES > LOCK_CYCLES) ? RST_CYCLES : LOCK_CYCLES;
    localparam int CNT_MAX = (MAX_RL > TIMEOUT_CYCLES) ? MAX_RL : TIMEOUT_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          w_locked_s;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [3:0]    r_retries;
    logic [3:0]    w_retries_nx;
    logic [3:0]    w_retries_inc;
    logic [7:0]    r_loss;
    logic [7:0]    w_loss_nx;

    logic          r_pll_rst;
    logic          r_sys_rst;
    logic          r_ready;
    logic          r_fail;
    logic          w_pll_rst_nx;
    logic          w_sys_rst_nx;
    logic          w_ready_nx;
    logic          w_fail_nx;

    // locked is asynchronous to refclk
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_locked_s = r_sync2;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RST;
            r_cnt     <= '0;
            r_retries <= '0;
            r_loss    <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_retries <= w_retries_nx;
            r_loss    <= w_loss_nx;
            r_pll_rst <= w_pll_rst_nx;
            r_sys_rst <= w_sys_rst_nx;
            r_ready   <= w_ready_nx;
            r_fail    <= w_fail_nx;
        end
    end

    assign w_retries_inc = (r_retries == 4'hF) ? r_retries : r_retries + 4'd1;

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_retries_nx = r_retries;
        w_loss_nx    = r_loss;

        if (req) begin
            w_state_nx   = ST_RST;
            w_cnt_nx     = '0;
            w_retries_nx = '0;
        end else begin
            case (r_state)
                ST_RST: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_nx = ST_WAIT;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                // A lock seen on the timeout cycle takes precedence over the retry
                ST_WAIT: begin
                    if (w_locked_s) begin
                        w_state_nx = ST_STABLE;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_retries_nx = w_retries_inc;
                        w_cnt_nx     = '0;
                        if (int'(w_retries_inc) == RETRY_MAX) begin
                            w_state_nx = ST_FAIL;
                        end else begin
                            w_state_nx = ST_RST;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        w_state_nx = ST_WAIT;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        w_state_nx   = ST_RUN;
                        w_cnt_nx     = '0;
                        w_retries_nx = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                // Lock loss lets the PLL try to relock before another reset pulse
                ST_RUN: begin
                    w_cnt_nx = '0;
                    if (!w_locked_s) begin
                        w_state_nx = ST_WAIT;
                        w_loss_nx  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                    end
                end
                ST_FAIL: begin
                    w_cnt_nx = '0;
                end
                default: begin
                    w_state_nx = ST_RST;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they move with the transition
    always_comb begin
        w_pll_rst_nx = (w_state_nx == ST_RST) || (w_state_nx == ST_FAIL);
        w_sys_rst_nx = (w_state_nx != ST_RUN);
        w_ready_nx   = (w_state_nx == ST_RUN);
        w_fail_nx    = (w_state_nx == ST_FAIL);
    end

    assign pll_rst    = r_pll_rst;
    assign sys_rst    = r_sys_rst;
    assign ready      = r_ready;
    assign fail       = r_fail;
    assign retries    = r_retries;
    assign loss_count = r_loss;

endmodule
